// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: MIPS-subset encoder writing instruction memory; ENCODER_CHECKSUM_EN enables checksum
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [3:0]            mnem,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [15:0]           imm,
  input  logic [25:0]           jAddr,
  output logic                  imWe,
  output logic [ADDR_WIDTH-1:0] imAddr,
  output logic [31:0]           imData,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err,
  output logic [31:0]           checksum
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  localparam logic [ADDR_WIDTH:0] depth_c = (ADDR_WIDTH+1)'(DEPTH);
  state_t state, state_n;
  logic accept, legal;
  logic [31:0] word;
  assign inReady = state == LOAD && count < depth_c;
  assign accept = inValid && inReady && !start;
  assign full = state == FULL;
  always_comb begin
    word = '0;
    legal = 1'b1;
    case (mnem)
      4'd0:    word = {6'h23, rs, rt, imm};
      4'd1:    word = {6'h2B, rs, rt, imm};
      4'd2:    word = {6'h02, jAddr};
      4'd3:    word = {6'h00, rs, 15'd0, 6'h08};
      4'd4:    word = {6'h03, jAddr};
      4'd5:    word = {6'h04, rs, rt, imm};
      4'd6:    word = {6'h05, rs, rt, imm};
      4'd7:    word = {6'h0E, rs, rt, imm};
      4'd8:    word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd9:    word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd10:   word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    if (start) state_n = LOAD;
    else if (accept && legal && count == depth_c - 1'b1) state_n = FULL;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      imWe <= 1'b0;
      imAddr <= '0;
      imData <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      imWe <= accept && legal;
      if (start) begin
        count <= '0;
        err <= 1'b0;
      end else if (accept && legal) begin
        imAddr <= count[ADDR_WIDTH-1:0];
        imData <= word;
        count <= count + 1'b1;
      end else if (accept) err <= 1'b1;
    end
  end
`ifdef ENCODER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (accept && legal) checksum <= checksum ^ word;
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench with a field-table reference model
module tb_instr_encoder_loader;
  localparam int AW = 3;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, start = 0, inValid = 0;
  logic inReady, imWe, full, err;
  logic [3:0] mnem = 0;
  logic [4:0] rs = 0, rt = 0, rd = 0;
  logic [15:0] imm = 0;
  logic [25:0] jAddr = 0;
  logic [AW-1:0] imAddr;
  logic [31:0] imData, checksum;
  logic [AW:0] count;
  int n_checks = 0, n_fail = 0;
  bit mon_en = 0;
  typedef struct {int addr; logic [31:0] data;} exp_t;
  exp_t q[$];
  bit mload = 0, merr = 0;
  int mcnt = 0;
  logic [31:0] mck = 0;
  logic [31:0] ops[11] = '{32'h23, 32'h2B, 32'h02, 32'h00, 32'h03, 32'h04, 32'h05, 32'h0E, 32'h00, 32'h00, 32'h00};
  logic [31:0] fns[11] = '{0, 0, 0, 32'h08, 0, 0, 0, 0, 32'h20, 32'h22, 32'h2A};

  instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .inValid(inValid), .inReady(inReady),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jAddr(jAddr),
    .imWe(imWe), .imAddr(imAddr), .imData(imData), .count(count), .full(full),
    .err(err), .checksum(checksum));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(int m, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                      logic [15:0] i, logic [25:0] j);
    logic [31:0] w;
    w = ops[m] << 26;
    if (m inside {0, 1, 5, 6, 7}) w = w | (32'(s) << 21) | (32'(t) << 16) | 32'(i);
    else if (m inside {2, 4}) w = w | 32'(j);
    else if (m == 3) w = w | (32'(s) << 21) | fns[m];
    else w = w | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | fns[m];
    return w;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mload = 0; mcnt = 0; merr = 0; mck = 0;
      q.delete();
    end else if (start) begin
      mload = 1; mcnt = 0; merr = 0; mck = 0;
    end else if (inValid && mload && mcnt < DEPTH) begin
      if (mnem <= 10) begin
        q.push_back('{mcnt, enc(int'(mnem), rs, rt, rd, imm, jAddr)});
        mck = mck ^ enc(int'(mnem), rs, rt, rd, imm, jAddr);
        mcnt++;
      end else merr = 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("ready", 32'(inReady), 32'(mload && mcnt < DEPTH));
      chk("count", 32'(count), 32'(mcnt));
      chk("full", 32'(full), 32'(mcnt == DEPTH));
      chk("err", 32'(err), 32'(merr));
`ifdef ENCODER_CHECKSUM_EN
      chk("checksum", checksum, mck);
`else
      chk("checksum", checksum, 32'd0);
`endif
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("we", 32'(imWe), 32'd1);
        chk("addr", 32'(imAddr), 32'(e.addr));
        chk("data", imData, e.data);
      end else chk("we", 32'(imWe), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int m, int s, int t, int d, int i, int j);
    inValid = 1;
    mnem = 4'(m); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i); jAddr = 26'(j);
    step();
  endtask

  task automatic idle();
    inValid = 0;
    step();
  endtask

  task automatic pulse_start();
    start = 1;
    idle();
    start = 0;
  endtask

  initial begin
    step();
    mon_en = 1;
    step();
    chk("rst_ready", 32'(inReady), 0);
    chk("rst_we", 32'(imWe), 0);
    chk("rst_addr", 32'(imAddr), 0);
    chk("rst_data", imData, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cksum", checksum, 0);
    reset = 0;
    pulse_start();
    chk("start_ready", 32'(inReady), 1);
    put(0, 2, 3, 0, 'h10, 0);
    chk("lw_we", 32'(imWe), 1);
    chk("lw_addr", 32'(imAddr), 0);
    chk("lw_data", imData, 32'h8C430010);
    chk("lw_count", 32'(count), 1);
    idle();
    pulse_start();
    put(2, 0, 0, 0, 0, 'h100);
    chk("j_data", imData, 32'h08000100);
    chk("j_addr", 32'(imAddr), 0);
    put(3, 31, 7, 0, 0, 0);
    chk("jr_we", 32'(imWe), 1);
    chk("jr_data", imData, 32'h03E00008);
    chk("jr_addr", 32'(imAddr), 1);
    put(8, 2, 3, 1, 'hFFFF, 0);
    chk("add_data", imData, 32'h00430820);
    put(12, 1, 1, 1, 1, 1);
    chk("ill_we", 32'(imWe), 0);
    chk("ill_err", 32'(err), 1);
    chk("ill_count", 32'(count), 3);
    put(1, 0, 5, 0, 4, 0);
    chk("sw_data", imData, 32'h AC050004);
    chk("sw_addr", 32'(imAddr), 3);
    chk("sw_full", 32'(full), 1);
    idle();
    pulse_start();
    for (int k = 0; k < 6; k++) put(k % 11, k, k + 1, k + 2, k * 3, k * 5);
    idle();
    chk("stream_count", 32'(count), 4);
    chk("stream_full", 32'(full), 1);
    chk("stream_ready", 32'(inReady), 0);
    pulse_start();
    chk("restart_count", 32'(count), 0);
    chk("restart_full", 32'(full), 0);
    put(0, 2, 3, 0, 'h10, 0);
    put(2, 0, 0, 0, 0, 'h100);
`ifdef ENCODER_CHECKSUM_EN
    chk("cksum2", checksum, 32'h84430110);
`else
    chk("cksum2", checksum, 32'h0);
`endif
    reset = 1;
    put(7, 4, 5, 6, 'h1234, 0);
    chk("rstmid_we", 32'(imWe), 0);
    chk("rstmid_cksum", checksum, 0);
    chk("rstmid_count", 32'(count), 0);
    reset = 0;
    pulse_start();
    put(0, 1, 1, 0, 1, 0);
    start = 1;
    put(1, 2, 2, 0, 2, 0);
    start = 0;
    chk("startwin_we", 32'(imWe), 0);
    chk("startwin_count", 32'(count), 0);
    for (int k = 0; k < 400; k++) begin
      reset = $urandom_range(0, 63) == 0;
      start = $urandom_range(0, 9) == 0;
      put(int'($urandom_range(0, 15)), int'($urandom), int'($urandom), int'($urandom),
          int'($urandom), int'($urandom));
      inValid = $urandom_range(0, 3) != 0;
    end
    reset = 0;
    start = 0;
    idle();
    idle();
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
